// File: rtl/uart_tx_queue_if.sv
// Bundle between a byte writer / UART transmitter pair and uart_tx_queue.
// The optional flush input exists only when UART_TXQ_FLUSH_EN is defined.
interface uart_tx_queue_if #(
  parameter int DWIDTH = 8
);
  // Handshakes: a write is taken on a posedge where wr_en=1 and full=0. tx_start is a
  // one-cycle pulse with tx_din valid from then until the next pop; the transmitter
  // answers with a one-cycle tx_done_tick at the end of the stop bit.
  logic              wr_en;
  logic [DWIDTH-1:0] wr_data;
  logic              full;
  logic              almost_full;
  logic              empty;
  logic              overflow;
  logic              tx_start;
  logic [DWIDTH-1:0] tx_din;
  logic              tx_done_tick;
  logic              busy;
  logic [1:0]        dbg_state;
`ifdef UART_TXQ_FLUSH_EN
  logic              flush;

  modport slave (
    input  wr_en, wr_data, tx_done_tick, flush,
    output full, almost_full, empty, overflow, tx_start, tx_din, busy, dbg_state
  );
  modport master (
    output wr_en, wr_data, tx_done_tick, flush,
    input  full, almost_full, empty, overflow, tx_start, tx_din, busy, dbg_state
  );
`else
  modport slave (
    input  wr_en, wr_data, tx_done_tick,
    output full, almost_full, empty, overflow, tx_start, tx_din, busy, dbg_state
  );
  modport master (
    output wr_en, wr_data, tx_done_tick,
    input  full, almost_full, empty, overflow, tx_start, tx_din, busy, dbg_state
  );
`endif
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus IDLE/ISSUE/WAIT issue FSM feeding a UART transmitter.
// Optional feature macro: UART_TXQ_FLUSH_EN (adds a synchronous queue flush input).
module uart_tx_queue #(
  parameter int DWIDTH   = 8,
  parameter int ADDR_W   = 4,
  parameter int AFULL_TH = 12
) (
  input logic          clk,
  input logic          reset,
  uart_tx_queue_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DWIDTH-1:0] r_tx_din;
  logic              r_tx_start;
  logic              r_overflow;
  logic              r_busy;

  logic w_full;
  logic w_empty;
  logic w_afull;
  logic w_flush;
  logic w_wr_acc;
  logic w_pop;

`ifdef UART_TXQ_FLUSH_EN
  assign w_flush = bus.flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_afull  = (r_count >= CNT_W'(AFULL_TH));
  // Full is the registered value, so a same-cycle pop never makes room for a write.
  assign w_wr_acc = bus.wr_en && !w_full && !w_flush;
  assign w_pop    = (r_state == S_IDLE) && !w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= bus.wr_en && w_full && !w_flush;
    end
  end

  // Flush does not touch the FSM: a byte already popped is issued and waited on.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tx_din   <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx_start <= 1'b0;
          if (w_pop) begin
            r_tx_din   <= r_mem[r_rd_ptr];
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tx_start <= 1'b0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          r_tx_start <= 1'b0;
          if (bus.tx_done_tick) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.full        = w_full;
  assign bus.almost_full = w_afull;
  assign bus.empty       = w_empty;
  assign bus.overflow    = r_overflow;
  assign bus.tx_start    = r_tx_start;
  assign bus.tx_din      = r_tx_din;
  assign bus.busy        = r_busy;
  assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: reset, latency, overflow, almost_full, idle done
// tick, mid-frame reset and (with UART_TXQ_FLUSH_EN) flush.
module tb_uart_tx_queue;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  uart_tx_queue_if #(.DWIDTH(8)) bus ();

  uart_tx_queue #(.DWIDTH(8), .ADDR_W(4), .AFULL_TH(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the edge; checks see the settled registered outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.tx_done_tick = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_done();
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h3C;
    bus.tx_done_tick = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags empty=%b full=%b afull=%b want 1 0 0",
               bus.empty, bus.full, bus.almost_full);
    end
    n_checks++;
    if (bus.overflow !== 1'b0 || bus.tx_start !== 1'b0 || bus.busy !== 1'b0 ||
        bus.tx_din !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_outputs ovf=%b start=%b busy=%b din=%h want 0 0 0 00",
               bus.overflow, bus.tx_start, bus.busy, bus.tx_din);
    end
    reset = 1'b0;
    bus.wr_en = 1'b0;
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic test_latency();
    apply_reset();
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hA5;
    tick();
    bus.wr_en = 1'b0;
    n_checks++;
    if (bus.empty !== 1'b0 || bus.tx_start !== 1'b0) begin
      n_errors++;
      $display("FAIL lat_cycle1 empty=%b start=%b want 0 0", bus.empty, bus.tx_start);
    end
    tick();
    n_checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_din !== 8'hA5 || bus.busy !== 1'b1 || bus.empty !== 1'b1) begin
      n_errors++;
      $display("FAIL lat_cycle2 start=%b din=%h busy=%b empty=%b want 1 a5 1 1",
               bus.tx_start, bus.tx_din, bus.busy, bus.empty);
    end
    tick();
    tick();
    n_checks++;
    if (bus.tx_start !== 1'b0 || bus.busy !== 1'b1 || bus.dbg_state !== 2'd2) begin
      n_errors++;
      $display("FAIL lat_wait start=%b busy=%b state=%0d want 0 1 2",
               bus.tx_start, bus.busy, bus.dbg_state);
    end
    pulse_done();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.tx_din !== 8'hA5) begin
      n_errors++;
      $display("FAIL lat_done busy=%b din=%h want 0 a5", bus.busy, bus.tx_din);
    end
  endtask

  task automatic test_overflow();
    bit seen;
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        n_checks++;
        if (bus.full !== 1'b0) begin
          n_errors++;
          $display("FAIL ovf_not_full_c16 full=%b want 0", bus.full);
        end
      end
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(i);
      tick();
    end
    n_checks++;
    if (bus.full !== 1'b1 || bus.almost_full !== 1'b1 || bus.overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_full_c17 full=%b afull=%b ovf=%b want 1 1 0",
               bus.full, bus.almost_full, bus.overflow);
    end
    bus.wr_data = 8'hFF;
    tick();
    bus.wr_en = 1'b0;
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.full !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_pulse ovf=%b full=%b want 1 1", bus.overflow, bus.full);
    end
    tick();
    n_checks++;
    if (bus.overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_one_cycle ovf=%b want 0", bus.overflow);
    end
    for (int k = 1; k <= 16; k++) begin
      pulse_done();
      seen = 1'b0;
      for (int t = 0; t < 8 && !seen; t++) begin
        if (bus.tx_start === 1'b1) seen = 1'b1;
        else tick();
      end
      n_checks++;
      if (!seen || bus.tx_din !== 8'(k)) begin
        n_errors++;
        $display("FAIL ovf_drain_%0d started=%b din=%h want 1 %h", k, seen, bus.tx_din, 8'(k));
      end
      tick();
    end
    pulse_done();
    seen = 1'b0;
    for (int t = 0; t < 6; t++) begin
      if (bus.tx_start === 1'b1) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen || bus.empty !== 1'b1 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_no_extra start_seen=%b empty=%b busy=%b want 0 1 0",
               seen, bus.empty, bus.busy);
    end
  endtask

  task automatic test_almost_full();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'h40 + i);
      tick();
    end
    n_checks++;
    if (bus.almost_full !== 1'b0 || bus.empty !== 1'b0) begin
      n_errors++;
      $display("FAIL afull_11 afull=%b empty=%b want 0 0", bus.almost_full, bus.empty);
    end
    bus.wr_data = 8'h4C;
    tick();
    bus.wr_en = 1'b0;
    n_checks++;
    if (bus.almost_full !== 1'b1 || bus.full !== 1'b0) begin
      n_errors++;
      $display("FAIL afull_12 afull=%b full=%b want 1 0", bus.almost_full, bus.full);
    end
    pulse_done();
    n_checks++;
    if (bus.almost_full !== 1'b1 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL afull_idle afull=%b busy=%b want 1 0", bus.almost_full, bus.busy);
    end
    tick();
    n_checks++;
    if (bus.almost_full !== 1'b0 || bus.tx_start !== 1'b1 || bus.tx_din !== 8'h41) begin
      n_errors++;
      $display("FAIL afull_pop afull=%b start=%b din=%h want 0 1 41",
               bus.almost_full, bus.tx_start, bus.tx_din);
    end
  endtask

  task automatic test_idle_done_and_reset();
    bit seen;
    apply_reset();
    pulse_done();
    seen = 1'b0;
    for (int t = 0; t < 4; t++) begin
      if (bus.tx_start === 1'b1 || bus.dbg_state !== 2'd0 || bus.busy !== 1'b0) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen || bus.empty !== 1'b1) begin
      n_errors++;
      $display("FAIL idle_done disturbed=%b empty=%b want 0 1", seen, bus.empty);
    end
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'h60 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    n_checks++;
    if (bus.dbg_state !== 2'd2 || bus.busy !== 1'b1 || bus.empty !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_pre state=%0d busy=%b empty=%b want 2 1 0",
               bus.dbg_state, bus.busy, bus.empty);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (bus.empty !== 1'b1 || bus.busy !== 1'b0 || bus.tx_din !== 8'h00 || bus.dbg_state !== 2'd0) begin
      n_errors++;
      $display("FAIL midrst_post empty=%b busy=%b din=%h state=%0d want 1 0 00 0",
               bus.empty, bus.busy, bus.tx_din, bus.dbg_state);
    end
    seen = 1'b0;
    for (int t = 0; t < 4; t++) begin
      if (bus.tx_start === 1'b1) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("FAIL midrst_quiet start_seen=%b want 0", seen);
    end
  endtask

`ifdef UART_TXQ_FLUSH_EN
  task automatic test_flush();
    bit seen;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'h80 + i);
      tick();
    end
    bus.flush = 1'b1;
    bus.wr_data = 8'hEE;
    tick();
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    n_checks++;
    if (bus.empty !== 1'b1 || bus.overflow !== 1'b0 || bus.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_clear empty=%b ovf=%b busy=%b want 1 0 1",
               bus.empty, bus.overflow, bus.busy);
    end
    seen = 1'b0;
    for (int t = 0; t < 4; t++) begin
      if (bus.tx_start === 1'b1 || bus.busy !== 1'b1) seen = 1'b1;
      tick();
    end
    pulse_done();
    n_checks++;
    if (seen || bus.busy !== 1'b0 || bus.tx_din !== 8'h80) begin
      n_errors++;
      $display("FAIL flush_inflight disturbed=%b busy=%b din=%h want 0 0 80",
               seen, bus.busy, bus.tx_din);
    end
    seen = 1'b0;
    for (int t = 0; t < 4; t++) begin
      if (bus.tx_start === 1'b1) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen || bus.empty !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_no_issue start_seen=%b empty=%b want 0 1", seen, bus.empty);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.tx_done_tick = 1'b0;
`ifdef UART_TXQ_FLUSH_EN
    bus.flush = 1'b0;
`endif
    test_reset();
    test_latency();
    test_overflow();
    test_almost_full();
    test_idle_done_and_reset();
`ifdef UART_TXQ_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
